// File: rtl/vx_vec_lane_sequencer_pkg.sv
// Shared vector-execute types and constants.
//   LANEID_BITS / NR_BITS : lane-group tag width and register-index width
//   op_args_t             : operation argument bundle carried with each packet
//   seq_state_e           : idle/busy state encoding shared by vector sequencers
//   exec_hdr_t            : lane-independent part of an execute packet
package vx_vec_lane_sequencer_pkg;

   localparam int LANEID_BITS = 2;
   localparam int NR_BITS     = 5;
   localparam int UUID_BITS   = 32;
   localparam int WID_BITS    = 2;
   localparam int PC_BITS     = 32;
   localparam int OPTYPE_BITS = 4;
   localparam int TID_BITS    = 2;
   localparam int PID_BITS    = 1;

   typedef struct packed {
      logic        use_pc;
      logic        use_imm;
      logic [31:0] imm;
   } op_args_t;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_BUSY = 1'b1
   } seq_state_e;

   typedef struct packed {
      logic [UUID_BITS-1:0]   uuid;
      logic [WID_BITS-1:0]    wid;
      logic [PC_BITS-1:0]     PC;
      logic [OPTYPE_BITS-1:0] op_type;
      op_args_t               op_args;
      logic                   wb;
      logic [NR_BITS-1:0]     rd;
      logic [NR_BITS-1:0]     vd;
      logic [TID_BITS-1:0]    tid;
      logic [PID_BITS-1:0]    pid;
      logic                   sop;
      logic                   eop;
      logic                   is_vec;
      logic [LANEID_BITS-1:0] vd_lane_id;
      logic                   vd_is_last;
   } exec_hdr_t;

endpackage

// File: rtl/VX_execute_if.sv
// Execute-stage packet interface.
//   valid/ready : handshake (master drives valid and payload, slave drives ready)
//   hdr         : lane-independent packet fields
//   tmask       : per-lane thread mask
//   rs1/2/3_data: per-lane source operands
interface VX_execute_if #(
   parameter int NUM_LANES = 1
) ();
   import vx_vec_lane_sequencer_pkg::*;

   logic                       valid;
   logic                       ready;
   exec_hdr_t                  hdr;
   logic [NUM_LANES-1:0]       tmask;
   logic [NUM_LANES-1:0][31:0] rs1_data;
   logic [NUM_LANES-1:0][31:0] rs2_data;
   logic [NUM_LANES-1:0][31:0] rs3_data;

   modport master (
      output valid, hdr, tmask, rs1_data, rs2_data, rs3_data,
      input  ready
   );

   modport slave (
      input  valid, hdr, tmask, rs1_data, rs2_data, rs3_data,
      output ready
   );
endinterface

// File: rtl/vx_perf_counter.sv
// Free-running event counter, wraps modulo 2^WIDTH.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count enable for this cycle
//   value      : current count
module vx_perf_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (inc) begin
         value <= value + WIDTH'(1);
      end
   end

endmodule

// File: rtl/vx_vec_lane_sequencer.sv
// Expands vector execute packets into NUM_VLANE_BEATS lane-group beats;
// scalar packets pass through as a single beat. Registered output stage.
//   clk, reset        : clock, asynchronous active-high reset
//   exec_in_if        : upstream packet stream (slave)
//   exec_out_if       : sequenced beat stream (master)
//   busy              : vector beats still pending after the current one
//   perf_vec_pkts     : vector packets accepted
//   perf_stall_cycles : cycles with output valid and not ready
module vx_vec_lane_sequencer
   import vx_vec_lane_sequencer_pkg::*;
#(
   parameter int NUM_LANES       = 1,
   parameter int NUM_VLANE_BEATS = 4,
   parameter int PERF_CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   VX_execute_if.slave           exec_in_if,
   VX_execute_if.master          exec_out_if,
   output logic                  busy,
   output logic [PERF_CNT_W-1:0] perf_vec_pkts,
   output logic [PERF_CNT_W-1:0] perf_stall_cycles
);

   localparam logic [0:0] ST_IDLE = SEQ_IDLE;
   localparam logic [0:0] ST_SEQ  = SEQ_BUSY;
   localparam logic [LANEID_BITS-1:0] LAST_BEAT = LANEID_BITS'(NUM_VLANE_BEATS - 1);
   localparam bit SINGLE_BEAT = (NUM_VLANE_BEATS == 1);

   logic [0:0]                 state;
   logic                       out_valid;
   exec_hdr_t                  out_hdr;
   logic [NUM_LANES-1:0]       out_tmask;
   logic [NUM_LANES-1:0][31:0] out_rs1;
   logic [NUM_LANES-1:0][31:0] out_rs2;
   logic [NUM_LANES-1:0][31:0] out_rs3;
   logic [LANEID_BITS-1:0]     beat_cnt;
   logic                       held_eop;   // input eop, deferred to the last beat

   logic                       in_ready;
   logic                       in_fire;
   logic                       out_fire;
   logic [LANEID_BITS-1:0]     next_beat;
   exec_hdr_t                  load_hdr;
   exec_hdr_t                  step_hdr;

   // Only a final beat leaving makes room; ready never depends on in valid.
   assign in_ready  = !out_valid || (exec_out_if.ready && out_hdr.vd_is_last);
   assign in_fire   = exec_in_if.valid && in_ready;
   assign out_fire  = out_valid && exec_out_if.ready;
   assign next_beat = beat_cnt + LANEID_BITS'(1);

   // First beat of a newly accepted packet.
   always_comb begin
      load_hdr            = exec_in_if.hdr;
      load_hdr.vd_lane_id = '0;
      if (exec_in_if.hdr.is_vec && !SINGLE_BEAT) begin
         load_hdr.vd_is_last = 1'b0;
         load_hdr.eop        = 1'b0;
      end else begin
         load_hdr.vd_is_last = 1'b1;
      end
   end

   // Following beat of a vector packet: only the tags change.
   always_comb begin
      step_hdr            = out_hdr;
      step_hdr.vd_lane_id = next_beat;
      step_hdr.sop        = 1'b0;
      if (next_beat == LAST_BEAT) begin
         step_hdr.vd_is_last = 1'b1;
         step_hdr.eop        = held_eop;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_hdr   <= '0;
         out_tmask <= '0;
         out_rs1   <= '0;
         out_rs2   <= '0;
         out_rs3   <= '0;
         beat_cnt  <= '0;
         held_eop  <= 1'b0;
      end else if (in_fire) begin
         // Takes priority: it can coincide with the last beat leaving.
         out_valid <= 1'b1;
         out_hdr   <= load_hdr;
         out_tmask <= exec_in_if.tmask;
         out_rs1   <= exec_in_if.rs1_data;
         out_rs2   <= exec_in_if.rs2_data;
         out_rs3   <= exec_in_if.rs3_data;
         beat_cnt  <= '0;
         held_eop  <= exec_in_if.hdr.eop;
         state     <= (exec_in_if.hdr.is_vec && !SINGLE_BEAT) ? ST_SEQ : ST_IDLE;
      end else if (out_fire) begin
         if (state == ST_SEQ) begin
            out_hdr  <= step_hdr;
            beat_cnt <= next_beat;
            if (next_beat == LAST_BEAT) begin
               state <= ST_IDLE;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   assign exec_in_if.ready      = in_ready;
   assign exec_out_if.valid     = out_valid;
   assign exec_out_if.hdr       = out_hdr;
   assign exec_out_if.tmask     = out_tmask;
   assign exec_out_if.rs1_data  = out_rs1;
   assign exec_out_if.rs2_data  = out_rs2;
   assign exec_out_if.rs3_data  = out_rs3;
   assign busy                  = (state == ST_SEQ);

   vx_perf_counter #(.WIDTH(PERF_CNT_W)) u_vec_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (in_fire && exec_in_if.hdr.is_vec),
      .value (perf_vec_pkts)
   );

   vx_perf_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid && !exec_out_if.ready),
      .value (perf_stall_cycles)
   );

   a_beats_range: assert property (@(posedge clk)
      (NUM_VLANE_BEATS >= 1) && (NUM_VLANE_BEATS <= (1 << LANEID_BITS)));

   a_hold_on_stall: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !exec_out_if.ready) |=>
         ($stable(out_hdr) && $stable(out_tmask) && $stable(out_rs1)
          && $stable(out_rs2) && $stable(out_rs3)));

   a_lane_range: assert property (@(posedge clk) disable iff (reset)
      out_valid |-> ({1'b0, out_hdr.vd_lane_id} < (LANEID_BITS + 1)'(NUM_VLANE_BEATS)));

endmodule

// File: tb/tb_vx_vec_lane_sequencer.sv
module tb_vx_vec_lane_sequencer;
   import vx_vec_lane_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   VX_execute_if #(.NUM_LANES(1)) in_if ();
   VX_execute_if #(.NUM_LANES(1)) out_if ();
   VX_execute_if #(.NUM_LANES(1)) in_if1 ();
   VX_execute_if #(.NUM_LANES(1)) out_if1 ();

   logic        busy, busy1;
   logic [31:0] pv, ps, pv1, ps1;

   vx_vec_lane_sequencer #(.NUM_LANES(1), .NUM_VLANE_BEATS(4), .PERF_CNT_W(32)) dut (
      .clk(clk), .reset(reset), .exec_in_if(in_if), .exec_out_if(out_if),
      .busy(busy), .perf_vec_pkts(pv), .perf_stall_cycles(ps)
   );

   vx_vec_lane_sequencer #(.NUM_LANES(1), .NUM_VLANE_BEATS(1), .PERF_CNT_W(32)) dut1 (
      .clk(clk), .reset(reset), .exec_in_if(in_if1), .exec_out_if(out_if1),
      .busy(busy1), .perf_vec_pkts(pv1), .perf_stall_cycles(ps1)
   );

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] uuid, input logic vec, input logic sop,
                       input logic eop, input logic [4:0] vd);
      in_if.hdr            = '0;
      in_if.hdr.uuid       = uuid;
      in_if.hdr.wid        = 2'd1;
      in_if.hdr.PC         = 32'h1000 + uuid;
      in_if.hdr.wb         = 1'b1;
      in_if.hdr.rd         = 5'd3;
      in_if.hdr.vd         = vd;
      in_if.hdr.is_vec     = vec;
      in_if.hdr.sop        = sop;
      in_if.hdr.eop        = eop;
      in_if.hdr.vd_lane_id = 2'd3;   // junk tags the block must overwrite
      in_if.hdr.vd_is_last = 1'b0;
      in_if.tmask          = 1'b1;
      in_if.rs1_data[0]    = uuid ^ 32'hA5A5_0000;
      in_if.valid          = 1'b1;
      $display("send uuid=%0d vec=%0b sop=%0b eop=%0b vd=%0d", uuid, vec, sop, eop, vd);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_if.valid, busy, pv, ps, in_if.ready} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got v=%0b busy=%0b pv=%0d ps=%0d rdy=%0b want 0 0 0 0 1",
                  out_if.valid, busy, pv, ps, in_if.ready);
      end
      checks++;
      if ({out_if1.valid, busy1, pv1} !== {1'b0, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL reset_state_b1 got v=%0b busy=%0b pv=%0d want 0 0 0",
                  out_if1.valid, busy1, pv1);
      end
      reset = 1'b0;
   endtask

   task automatic test_scalar_b2b();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            checks++;
            if ({out_if.valid, out_if.hdr.uuid, out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last}
                !== {1'b1, 32'(10 + i - 1), 2'd0, 1'b1}) begin
               errors++;
               $display("FAIL scalar_beat%0d got v=%0b uuid=%0d lane=%0d last=%0b want 1 %0d 0 1",
                        i - 1, out_if.valid, out_if.hdr.uuid, out_if.hdr.vd_lane_id,
                        out_if.hdr.vd_is_last, 10 + i - 1);
            end
         end
         if (i < 3) begin
            send(32'(10 + i), 1'b0, 1'b1, 1'b1, 5'd5);
            checks++;
            if (in_if.ready !== 1'b1) begin
               errors++;
               $display("FAIL scalar_in_ready%0d got %0b want 1", i, in_if.ready);
            end
         end else begin
            in_if.valid = 1'b0;
         end
         step();
      end
      checks++;
      if (out_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL scalar_drain got v=%0b want 0", out_if.valid);
      end
   endtask

   task automatic test_vector();
      send(32'd20, 1'b1, 1'b1, 1'b1, 5'd7);
      step();
      in_if.valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         checks++;
         if ({out_if.valid, out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last, out_if.hdr.sop,
              out_if.hdr.eop, out_if.hdr.uuid, out_if.hdr.vd, out_if.hdr.is_vec, out_if.rs1_data[0]}
             !== {1'b1, 2'(b), (b == 3), (b == 0), (b == 3), 32'd20, 5'd7, 1'b1,
                  32'd20 ^ 32'hA5A5_0000}) begin
            errors++;
            $display("FAIL vec_beat%0d got v=%0b lane=%0d last=%0b sop=%0b eop=%0b uuid=%0d vd=%0d rs1=%0h",
                     b, out_if.valid, out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last, out_if.hdr.sop,
                     out_if.hdr.eop, out_if.hdr.uuid, out_if.hdr.vd, out_if.rs1_data[0]);
         end
         checks++;
         if ({busy, in_if.ready} !== {(b < 3), (b == 3)}) begin
            errors++;
            $display("FAIL vec_busy_rdy%0d got busy=%0b rdy=%0b want %0b %0b",
                     b, busy, in_if.ready, (b < 3), (b == 3));
         end
         step();
      end
      checks++;
      if ({out_if.valid, busy, pv} !== {1'b0, 1'b0, 32'd1}) begin
         errors++;
         $display("FAIL vec_done got v=%0b busy=%0b pv=%0d want 0 0 1", out_if.valid, busy, pv);
      end
   endtask

   task automatic test_backpressure();
      logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int exp_lane = 0;
      send(32'd30, 1'b1, 1'b0, 1'b1, 5'd9);
      step();
      in_if.valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         out_if.ready = pat[k];
         checks++;
         if ({out_if.valid, out_if.hdr.vd_lane_id, out_if.hdr.uuid, in_if.ready}
             !== {1'b1, 2'(exp_lane), 32'd30, (pat[k] && exp_lane == 3)}) begin
            errors++;
            $display("FAIL bp_cycle%0d got v=%0b lane=%0d uuid=%0d rdy=%0b want 1 %0d 30 %0b",
                     k, out_if.valid, out_if.hdr.vd_lane_id, out_if.hdr.uuid, in_if.ready,
                     exp_lane, (pat[k] && exp_lane == 3));
         end
         if (pat[k]) exp_lane++;
         else exp_stall++;
         step();
      end
      out_if.ready = 1'b1;
      checks++;
      if ({out_if.valid, ps, pv} !== {1'b0, 32'(exp_stall), 32'd2}) begin
         errors++;
         $display("FAIL bp_counters got v=%0b ps=%0d pv=%0d want 0 %0d 2",
                  out_if.valid, ps, pv, exp_stall);
      end
   endtask

   task automatic test_back_to_back();
      send(32'd40, 1'b1, 1'b1, 1'b0, 5'd2);
      step();
      in_if.valid = 1'b0;
      step();                       // beat 0 leaves
      step();                       // beat 1 leaves
      out_if.ready = 1'b0;          // beat 2 stalls while a scalar waits
      send(32'd41, 1'b0, 1'b1, 1'b1, 5'd4);
      checks++;
      if ({out_if.hdr.vd_lane_id, in_if.ready} !== {2'd2, 1'b0}) begin
         errors++;
         $display("FAIL q_stall got lane=%0d rdy=%0b want 2 0", out_if.hdr.vd_lane_id, in_if.ready);
      end
      exp_stall++;
      step();
      out_if.ready = 1'b1;
      checks++;
      if ({out_if.hdr.vd_lane_id, in_if.ready} !== {2'd2, 1'b0}) begin
         errors++;
         $display("FAIL q_held got lane=%0d rdy=%0b want 2 0", out_if.hdr.vd_lane_id, in_if.ready);
      end
      step();
      checks++;
      if ({out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last, in_if.ready} !== {2'd3, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL q_last got lane=%0d last=%0b rdy=%0b want 3 1 1",
                  out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last, in_if.ready);
      end
      step();
      in_if.valid = 1'b0;
      checks++;
      if ({out_if.valid, out_if.hdr.uuid, out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last, out_if.hdr.is_vec}
          !== {1'b1, 32'd41, 2'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL q_scalar got v=%0b uuid=%0d lane=%0d last=%0b vec=%0b want 1 41 0 1 0",
                  out_if.valid, out_if.hdr.uuid, out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last,
                  out_if.hdr.is_vec);
      end
      step();
      checks++;
      if ({out_if.valid, ps, pv} !== {1'b0, 32'(exp_stall), 32'd3}) begin
         errors++;
         $display("FAIL q_counters got v=%0b ps=%0d pv=%0d want 0 %0d 3",
                  out_if.valid, ps, pv, exp_stall);
      end
   endtask

   task automatic test_async_reset();
      send(32'd50, 1'b1, 1'b1, 1'b1, 5'd1);
      step();
      in_if.valid = 1'b0;
      step();
      checks++;
      if ({out_if.valid, out_if.hdr.vd_lane_id} !== {1'b1, 2'd1}) begin
         errors++;
         $display("FAIL ar_pre got v=%0b lane=%0d want 1 1", out_if.valid, out_if.hdr.vd_lane_id);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({out_if.valid, busy, pv, ps} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL ar_immediate got v=%0b busy=%0b pv=%0d ps=%0d want 0 0 0 0",
                  out_if.valid, busy, pv, ps);
      end
      step();
      reset = 1'b0;
      exp_stall = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({out_if.valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ar_no_residue%0d got v=%0b busy=%0b want 0 0", i, out_if.valid, busy);
         end
      end
      send(32'd51, 1'b0, 1'b1, 1'b1, 5'd6);
      step();
      in_if.valid = 1'b0;
      checks++;
      if ({out_if.valid, out_if.hdr.uuid, out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last}
          !== {1'b1, 32'd51, 2'd0, 1'b1}) begin
         errors++;
         $display("FAIL ar_next got v=%0b uuid=%0d lane=%0d last=%0b want 1 51 0 1",
                  out_if.valid, out_if.hdr.uuid, out_if.hdr.vd_lane_id, out_if.hdr.vd_is_last);
      end
      step();
   endtask

   task automatic test_single_beat();
      in_if1.hdr         = '0;
      in_if1.hdr.uuid    = 32'd60;
      in_if1.hdr.is_vec  = 1'b1;
      in_if1.hdr.sop     = 1'b1;
      in_if1.hdr.eop     = 1'b1;
      in_if1.hdr.vd_lane_id = 2'd2;
      in_if1.valid       = 1'b1;
      $display("send uuid=60 vec=1 sop=1 eop=1 (single-beat build)");
      checks++;
      if ({in_if1.ready, busy1} !== 2'b10) begin
         errors++;
         $display("FAIL sb_pre got rdy=%0b busy=%0b want 1 0", in_if1.ready, busy1);
      end
      step();
      in_if1.valid = 1'b0;
      checks++;
      if ({out_if1.valid, out_if1.hdr.vd_lane_id, out_if1.hdr.vd_is_last, out_if1.hdr.sop,
           out_if1.hdr.eop, out_if1.hdr.uuid, busy1, pv1}
          !== {1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'd60, 1'b0, 32'd1}) begin
         errors++;
         $display("FAIL sb_beat got v=%0b lane=%0d last=%0b sop=%0b eop=%0b uuid=%0d busy=%0b pv=%0d want 1 0 1 1 1 60 0 1",
                  out_if1.valid, out_if1.hdr.vd_lane_id, out_if1.hdr.vd_is_last, out_if1.hdr.sop,
                  out_if1.hdr.eop, out_if1.hdr.uuid, busy1, pv1);
      end
      step();
      checks++;
      if ({out_if1.valid, busy1} !== 2'b00) begin
         errors++;
         $display("FAIL sb_done got v=%0b busy=%0b want 0 0", out_if1.valid, busy1);
      end
   endtask

   initial begin
      in_if.valid   = 1'b0;
      in_if.hdr     = '0;
      in_if.tmask   = '0;
      in_if.rs1_data = '0;
      in_if.rs2_data = '0;
      in_if.rs3_data = '0;
      out_if.ready  = 1'b1;
      in_if1.valid  = 1'b0;
      in_if1.hdr    = '0;
      in_if1.tmask  = '0;
      in_if1.rs1_data = '0;
      in_if1.rs2_data = '0;
      in_if1.rs3_data = '0;
      out_if1.ready = 1'b1;

      test_reset();
      test_scalar_b2b();
      test_vector();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      test_single_beat();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
